mem_interface: RTL and testbench

Memory subsystem stage directly downstream of the CPU control unit. It owns the MAR and MDR registers and a word-addressed single-port RAM, and executes the control unit's mari/mdri/mdro/mem_read/mem_write strobes. It drives MDR onto the shared bus and reports busy/done so the control unit can stall on multi-cycle memory.

---
 rtl/mem_interface.sv | 145 ++++++++++++++
 tb/tb_mem_interface.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// mem_interface: memory stage behind the CPU control unit.
// This block holds MAR, MDR and a word-addressed single-port RAM. It carries
// out the control unit's register-load strobes and its memory strobes.
//
// Ports:
//   clock, reset        rising-edge clock; synchronous active-high reset
//   bus_in              shared bus value (MAR takes the low ADDR_WIDTH bits)
//   mari / mdri         load MAR / MDR from bus_in
//   mdro                put MDR onto mdr_bus_out (0 when low)
//   mem_read/mem_write  request strobes; each rising edge is one request
//   mar_q, mdr_q        current register contents
//   mem_busy            high while an operation is in flight
//   mem_done            one-cycle pulse after a read/write completes
//   mem_err             one-cycle pulse after a rejected request
//
// Handshake: the control unit raises mem_read or mem_write. A request is taken
// on the edge where the strobe is first seen high, and holding the level adds
// nothing. The block accepts a request only in IDLE when the other strobe is
// not also rising. Any other request is dropped and flagged on mem_err. Once a
// request is accepted, mem_busy stays high until completion, and mem_done marks
// the first cycle the result is visible.
module mem_interface #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 9,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  mari,
  input  logic                  mdri,
  input  logic                  mdro,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mdr_bus_out,
  output logic [ADDR_WIDTH-1:0] mar_q,
  output logic [DATA_WIDTH-1:0] mdr_q,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  mem_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] op_addr, op_addr_d;
  logic [DATA_WIDTH-1:0] op_data, op_data_d;
  logic                  rd_q, wr_q;
  logic                  rd_req, wr_req;
  logic                  done_d, err_d;
  logic                  rd_commit, wr_commit;

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  // Only a 0->1 transition of a strobe counts as a request.
  assign rd_req = mem_read & ~rd_q;
  assign wr_req = mem_write & ~wr_q;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    op_addr_d = op_addr;
    op_data_d = op_data;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_commit = 1'b0;
    wr_commit = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && wr_req) begin
          err_d = 1'b1;
        end else if (rd_req) begin
          op_addr_d = mar_q;
          cnt_d     = 4'(READ_LATENCY);
          state_d   = RD_WAIT;
        end else if (wr_req) begin
          op_addr_d = mar_q;
          op_data_d = mdr_q;
          cnt_d     = 4'(WRITE_LATENCY);
          state_d   = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // The operation in flight ignores new requests. Each one is flagged.
        err_d = rd_req | wr_req;
        if (cnt == 4'd1) begin
          rd_commit = (state == RD_WAIT);
          wr_commit = (state == WR_WAIT);
          done_d    = 1'b1;
          cnt_d     = 4'd0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_addr  <= '0;
      op_data  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mar_q    <= '0;
      mdr_q    <= '0;
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      op_addr  <= op_addr_d;
      op_data  <= op_data_d;
      rd_q     <= mem_read;
      wr_q     <= mem_write;
      mem_done <= done_d;
      mem_err  <= err_d;
      if (mari) mar_q <= bus_in[ADDR_WIDTH-1:0];
      // A read completion owns MDR. A bus load is accepted in IDLE and in
      // WR_WAIT, because the write data was already captured into op_data.
      if (rd_commit)
        mdr_q <= ram[op_addr];
      else if (mdri && !mem_read && state != RD_WAIT)
        mdr_q <= bus_in;
    end
  end

  // RAM is not cleared by reset. A reset on the commit edge blocks the write.
  always_ff @(posedge clock) begin
    if (wr_commit && !reset) ram[op_addr] <= op_data;
  end

  assign mem_busy    = (state != IDLE);
  assign mdr_bus_out = mdro ? mdr_q : '0;

endmodule

// File: tb/tb_mem_interface.sv
module tb_mem_interface;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] bus_in;
  logic          mari, mdri, mdro, mem_read, mem_write;
  logic [DW-1:0] mdr_bus_out;
  logic [AW-1:0] mar_q;
  logic [DW-1:0] mdr_q;
  logic          mem_busy, mem_done, mem_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // clock / reset
  always #5 clock = ~clock;

  mem_interface #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_LATENCY(2)
  ) dut (
    .clock(clock), .reset(reset), .bus_in(bus_in),
    .mari(mari), .mdri(mdri), .mdro(mdro),
    .mem_read(mem_read), .mem_write(mem_write),
    .mdr_bus_out(mdr_bus_out), .mar_q(mar_q), .mdr_q(mdr_q),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic load_mar(input logic [DW-1:0] v);
    bus_in = v; mari = 1'b1; tick(); mari = 1'b0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    bus_in = v; mdri = 1'b1; tick(); mdri = 1'b0;
  endtask

  // Strobe for one cycle, then wait until the operation has finished.
  task automatic do_write();
    mem_write = 1'b1; tick(); mem_write = 1'b0; tick(); tick(); tick();
  endtask

  task automatic do_read();
    mem_read = 1'b1; tick(); mem_read = 1'b0; tick(); tick(); tick();
  endtask

  int n_done, n_err;

  initial begin
    reset = 1'b1; bus_in = '0; mari = 0; mdri = 0; mdro = 0;
    mem_read = 0; mem_write = 0;
    tick(); tick();
    reset = 1'b0;
    check("reset_mar",  {23'd0, mar_q}, 32'h0);
    check("reset_mdr",  mdr_q, 32'h0);
    check("reset_busy", {31'd0, mem_busy}, 32'h0);
    check("reset_done", {31'd0, mem_done}, 32'h0);
    check("reset_err",  {31'd0, mem_err}, 32'h0);

    // 1. Bus loads
    load_mar(32'h0000_0045);
    load_mdr(32'hDEAD_BEEF);
    check("t1_mar", {23'd0, mar_q}, 32'h045);
    check("t1_mdr", mdr_q, 32'hDEAD_BEEF);
    mdro = 1'b1; #1;
    check("t1_mdro_on", mdr_bus_out, 32'hDEAD_BEEF);
    mdro = 1'b0; #1;
    check("t1_mdro_off", mdr_bus_out, 32'h0);

    // 2. Write and read back, checked cycle by cycle
    mem_write = 1'b1; tick(); mem_write = 1'b0;
    check("t2_wr_busy0", {31'd0, mem_busy}, 32'h1);
    tick();
    check("t2_wr_busy1", {31'd0, mem_busy}, 32'h1);
    check("t2_wr_nodone", {31'd0, mem_done}, 32'h0);
    tick();
    check("t2_wr_idle", {31'd0, mem_busy}, 32'h0);
    check("t2_wr_done", {31'd0, mem_done}, 32'h1);
    tick();
    check("t2_wr_done_off", {31'd0, mem_done}, 32'h0);
    load_mdr(32'h0);
    check("t2_mdr_clr", mdr_q, 32'h0);
    mem_read = 1'b1; tick(); mem_read = 1'b0;
    check("t2_rd_busy0", {31'd0, mem_busy}, 32'h1);
    tick();
    check("t2_rd_busy1", {31'd0, mem_busy}, 32'h1);
    check("t2_rd_early", mdr_q, 32'h0);
    tick();
    check("t2_rd_data", mdr_q, 32'hDEAD_BEEF);
    check("t2_rd_done", {31'd0, mem_done}, 32'h1);
    check("t2_rd_idle", {31'd0, mem_busy}, 32'h0);
    tick();
    check("t2_rd_done_off", {31'd0, mem_done}, 32'h0);

    // 3. Held level gives one read
    n_done = 0; n_err = 0;
    mem_read = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 5) mem_read = 1'b0;
      n_done += int'(mem_done);
      n_err  += int'(mem_err);
    end
    check("t3_done_cnt", n_done, 32'd1);
    check("t3_err_cnt",  n_err,  32'd0);

    // 4a. Read and write rising together
    load_mdr(32'h1234_5678);
    mem_read = 1'b1; mem_write = 1'b1; tick();
    mem_read = 1'b0; mem_write = 1'b0;
    check("t4a_err", {31'd0, mem_err}, 32'h1);
    check("t4a_busy", {31'd0, mem_busy}, 32'h0);
    tick();
    check("t4a_err_off", {31'd0, mem_err}, 32'h0);
    check("t4a_mdr", mdr_q, 32'h1234_5678);
    load_mdr(32'h0);
    do_read();
    check("t4a_ram", mdr_q, 32'hDEAD_BEEF);

    // 4b. Write rising during a read
    load_mdr(32'h0);
    mem_read = 1'b1; tick(); mem_read = 1'b0;
    mem_write = 1'b1; tick(); mem_write = 1'b0;
    check("t4b_err", {31'd0, mem_err}, 32'h1);
    check("t4b_busy", {31'd0, mem_busy}, 32'h1);
    tick();
    check("t4b_done", {31'd0, mem_done}, 32'h1);
    check("t4b_mdr", mdr_q, 32'hDEAD_BEEF);
    tick();

    // 5. MAR changes while a read is in flight
    load_mar(32'h0000_0010);
    load_mdr(32'h1111_1111);
    do_write();
    load_mdr(32'h0);
    mem_read = 1'b1; tick(); mem_read = 1'b0;
    bus_in = 32'hFFFF_FE20; mari = 1'b1; tick(); mari = 1'b0;
    tick();
    check("t5_mdr", mdr_q, 32'h1111_1111);
    check("t5_mar", {23'd0, mar_q}, 32'h020);
    check("t5_done", {31'd0, mem_done}, 32'h1);
    tick();

    // 6. Reset arrives before the write commits
    load_mar(32'h0000_007F);
    load_mdr(32'h0BAD_0BAD);
    do_write();
    load_mdr(32'hCAFE_F00D);
    mem_write = 1'b1; tick(); mem_write = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_mar", {23'd0, mar_q}, 32'h0);
    check("t6_mdr", mdr_q, 32'h0);
    check("t6_busy", {31'd0, mem_busy}, 32'h0);
    check("t6_done0", {31'd0, mem_done}, 32'h0);
    tick();
    check("t6_done1", {31'd0, mem_done}, 32'h0);
    tick();
    check("t6_done2", {31'd0, mem_done}, 32'h0);
    load_mar(32'h0000_007F);
    do_read();
    check("t6_ram", mdr_q, 32'h0BAD_0BAD);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
